// File: rtl/adder_result_accum_if.sv
// Pin-side bundle for the adder result accumulator: the adder result bus,
// the two asynchronous request pins and the accumulated result outputs.
interface adder_result_accum_if;
    logic [7:0] sum_in;
    logic       sample_in;
    logic       clear_in;
    logic [7:0] acc_out;
    logic       overflow;
    logic       busy;
    logic       out_valid;
    logic [3:0] sample_count;

    // Driver side (wrapper / testbench)
    modport master (
        output sum_in,
        output sample_in,
        output clear_in,
        input  acc_out,
        input  overflow,
        input  busy,
        input  out_valid,
        input  sample_count
    );

    // Accumulator side
    modport slave (
        input  sum_in,
        input  sample_in,
        input  clear_in,
        output acc_out,
        output overflow,
        output busy,
        output out_valid,
        output sample_count
    );
endinterface

// File: rtl/adder_result_accum.sv
// Adder result accumulator: synchronises the sample and clear pins, waits for
// the adder result to be stable for SETTLE_CYCLES cycles, then folds it into
// an 8-bit wrapping total with a sticky carry-out flag.
module adder_result_accum #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_result_accum_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ADD    = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    // 9-bit sum of two bytes; bit 8 is the carry out of bit 7
    function automatic logic [8:0] add_with_carry(input logic [7:0] a, input logic [7:0] b);
        add_with_carry = {1'b0, a} + {1'b0, b};
    endfunction

    state_t     state_r;
    state_t     next_state_s;

    logic       sample_meta_r;
    logic       sample_sync_r;
    logic       sample_prev_r;
    logic       clear_meta_r;
    logic       clear_sync_r;
    logic       sample_rise_s;

    logic [7:0] snap_r;
    logic [3:0] cnt_r;
    logic [7:0] acc_r;
    logic       overflow_r;
    logic [3:0] count_r;
    logic       out_valid_r;

    logic       snap_load_s;
    logic       cnt_clr_s;
    logic       cnt_inc_s;
    logic       do_add_s;
    logic [8:0] add_sum_s;

    assign sample_rise_s = sample_sync_r & ~sample_prev_r;
    assign add_sum_s     = add_with_carry(acc_r, snap_r);

    // Two-flop synchronisers for both pins plus the previous-value flop for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_meta_r <= 1'b0;
            sample_sync_r <= 1'b0;
            sample_prev_r <= 1'b0;
            clear_meta_r  <= 1'b0;
            clear_sync_r  <= 1'b0;
        end else begin
            sample_meta_r <= bus.sample_in;
            sample_sync_r <= sample_meta_r;
            sample_prev_r <= sample_sync_r;
            clear_meta_r  <= bus.clear_in;
            clear_sync_r  <= clear_meta_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and datapath control; synchronised clear overrides everything
    always_comb begin
        next_state_s = state_r;
        snap_load_s  = 1'b0;
        cnt_clr_s    = 1'b0;
        cnt_inc_s    = 1'b0;
        do_add_s     = 1'b0;
        if (clear_sync_r) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (sample_rise_s) begin
                        next_state_s = SETTLE;
                        snap_load_s  = 1'b1;
                        cnt_clr_s    = 1'b1;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                SETTLE: begin
                    if (bus.sum_in != snap_r) begin
                        // result moved: restart the stability window on the new value
                        snap_load_s = 1'b1;
                        cnt_clr_s   = 1'b1;
                    end else if (cnt_r == CNT_LAST) begin
                        next_state_s = ADD;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end
                ADD: begin
                    do_add_s     = 1'b1;
                    next_state_s = DONE;
                end
                DONE: begin
                    next_state_s = IDLE;
                end
                default: begin
                    next_state_s = IDLE;
                end
            endcase
        end
    end

    // Snapshot of the adder result and the stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_r <= 8'h00;
            cnt_r  <= 4'd0;
        end else if (clear_sync_r) begin
            cnt_r  <= 4'd0;
        end else begin
            if (snap_load_s) begin
                snap_r <= bus.sum_in;
            end
            if (cnt_clr_s) begin
                cnt_r <= 4'd0;
            end else if (cnt_inc_s) begin
                cnt_r <= cnt_r + 4'd1;
            end
        end
    end

    // Accumulator, sticky overflow, completion counter and update strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= 8'h00;
            overflow_r  <= 1'b0;
            count_r     <= 4'd0;
            out_valid_r <= 1'b0;
        end else if (clear_sync_r) begin
            acc_r       <= 8'h00;
            overflow_r  <= 1'b0;
            count_r     <= 4'd0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= do_add_s;
            if (do_add_s) begin
                acc_r      <= add_sum_s[7:0];
                overflow_r <= overflow_r | add_sum_s[8];
                count_r    <= count_r + 4'd1;
            end
        end
    end

    assign bus.acc_out      = acc_r;
    assign bus.overflow     = overflow_r;
    assign bus.sample_count = count_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.busy         = (state_r != IDLE);

endmodule
